// File: rtl/sram_arbiter_pkg.sv
// Shared SRAM bus header: bus widths, access-size encodings and the alignment rule
// used by every requester-facing block.
package sram_arbiter_pkg;

    localparam int SRAM_VA_WIDTH = 16;
    localparam int BUS_WIDTH     = 32;
    localparam int BUS_ACC_WIDTH = 2;

    localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;
    localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_2B = 2'd1;
    localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

    // Only the two low address bits matter for natural alignment.
    function automatic logic bus_misaligned(input logic [1:0]               addr_lo,
                                            input logic [BUS_ACC_WIDTH-1:0] acc);
        return (addr_lo[0] & (acc != BUS_ACC_1B)) |
               ((addr_lo == 2'd2) & (acc == BUS_ACC_4B));
    endfunction

endpackage

// File: rtl/dff.sv
// Common D flip-flop cell with synchronous active-low reset.
module dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk) begin
        if (!rstn) q_o <= RST_VAL;
        else       q_o <= d_i;
    end

endmodule

// File: rtl/sram_arb_slot.sv
// One pending-request slot: payload captured on load, valid held until cleared.
module sram_arb_slot #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load_i,
    input  logic         clr_i,
    input  logic [W-1:0] payload_i,
    output logic         valid_o,
    output logic [W-1:0] payload_o
);

    logic         valid_d;
    logic [W-1:0] payload_d;

    // Load beats clear so a request arriving in the completion cycle is kept.
    assign valid_d   = load_i | (valid_o & ~clr_i);
    assign payload_d = load_i ? payload_i : payload_o;

    dff #(.W(1)) u_vld (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (valid_d),
        .q_o  (valid_o)
    );

    dff #(.W(W)) u_pl (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (payload_d),
        .q_o  (payload_o)
    );

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of sram_controller: one pending slot per port,
// a single downstream access outstanding at a time.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int RR = 1
) (
    input  logic                     clk,
    input  logic                     rstn,

    input  logic [SRAM_VA_WIDTH-1:0] s0_addr,
    input  logic                     s0_w_rb,
    input  logic [BUS_ACC_WIDTH-1:0] s0_acc,
    input  logic [BUS_WIDTH-1:0]     s0_wdata,
    input  logic                     s0_req,
    output logic [BUS_WIDTH-1:0]     s0_rdata,
    output logic                     s0_resp,
    output logic                     s0_fault,

    input  logic [SRAM_VA_WIDTH-1:0] s1_addr,
    input  logic                     s1_w_rb,
    input  logic [BUS_ACC_WIDTH-1:0] s1_acc,
    input  logic [BUS_WIDTH-1:0]     s1_wdata,
    input  logic                     s1_req,
    output logic [BUS_WIDTH-1:0]     s1_rdata,
    output logic                     s1_resp,
    output logic                     s1_fault,

    output logic [SRAM_VA_WIDTH-1:0] m_addr,
    output logic                     m_w_rb,
    output logic [BUS_ACC_WIDTH-1:0] m_acc,
    output logic [BUS_WIDTH-1:0]     m_wdata,
    output logic                     m_req,
    input  logic [BUS_WIDTH-1:0]     m_rdata,
    input  logic                     m_resp,
    input  logic                     m_fault
);

    localparam int NP = 2;
    localparam int PW = SRAM_VA_WIDTH + 1 + BUS_ACC_WIDTH + BUS_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [NP-1:0]                    req, mis, busy, fault, load, resp, slot_vld;
    logic [NP-1:0][1:0]               addr_lo;
    logic [NP-1:0][BUS_ACC_WIDTH-1:0] acc;
    logic [NP-1:0][PW-1:0]            pl_in, pl_q;

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          winner;
    logic          active;
    logic [PW-1:0] owner_pl;
    logic          unused_m_fault;

    assign req     = {s1_req, s0_req};
    assign addr_lo = {s1_addr[1:0], s0_addr[1:0]};
    assign acc     = {s1_acc, s0_acc};
    assign pl_in   = {{s1_addr, s1_w_rb, s1_acc, s1_wdata},
                      {s0_addr, s0_w_rb, s0_acc, s0_wdata}};

    generate
        for (genvar g = 0; g < NP; g++) begin : g_port
            assign mis[g]   = bus_misaligned(addr_lo[g], acc[g]);
            assign resp[g]  = rstn & (state_q == ST_WAIT) & m_resp & (owner_q == 1'(g));
            // The slot frees up in its own completion cycle.
            assign busy[g]  = slot_vld[g] & ~resp[g];
            assign fault[g] = req[g] & (mis[g] | busy[g]);
            assign load[g]  = req[g] & ~fault[g];

            sram_arb_slot #(.W(PW)) u_slot (
                .clk       (clk),
                .rstn      (rstn),
                .load_i    (load[g]),
                .clr_i     (resp[g]),
                .payload_i (pl_in[g]),
                .valid_o   (slot_vld[g]),
                .payload_o (pl_q[g])
            );
        end
    endgenerate

    always_comb begin
        if (&slot_vld) winner = (RR != 0) ? ~last_q : 1'b0;
        else           winner = ~slot_vld[0];
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (|slot_vld) begin
                    owner_d = winner;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (m_resp) begin
                    last_d  = owner_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Outputs are gated by rstn so they read zero while reset is held.
    assign active   = rstn & ((state_q == ST_ISSUE) | (state_q == ST_WAIT));
    assign owner_pl = pl_q[owner_q];
    assign {m_addr, m_w_rb, m_acc, m_wdata} = active ? owner_pl : '0;
    assign m_req    = rstn & (state_q == ST_ISSUE);

    assign s0_resp  = resp[0];
    assign s0_rdata = resp[0] ? m_rdata : '0;
    assign s0_fault = fault[0];
    assign s1_resp  = resp[1];
    assign s1_rdata = resp[1] ? m_rdata : '0;
    assign s1_fault = fault[1];

    assign unused_m_fault = m_fault;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: an RR=1 and an RR=0 instance driven side by side and
// compared each cycle against a transaction-level model of slots and grants.
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam int ND = 2;
    localparam int VA = SRAM_VA_WIDTH;
    localparam int BW = BUS_WIDTH;
    localparam int AW = BUS_ACC_WIDTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn    [ND];
    logic          s_req   [ND][2];
    logic          s_w_rb  [ND][2];
    logic [VA-1:0] s_addr  [ND][2];
    logic [AW-1:0] s_acc   [ND][2];
    logic [BW-1:0] s_wdata [ND][2];
    logic [BW-1:0] s_rdata [ND][2];
    logic          s_resp  [ND][2];
    logic          s_fault [ND][2];
    logic [VA-1:0] m_addr  [ND];
    logic          m_w_rb  [ND];
    logic [AW-1:0] m_acc   [ND];
    logic [BW-1:0] m_wdata [ND];
    logic          m_req   [ND];
    logic [BW-1:0] m_rdata [ND];
    logic          m_resp  [ND];
    logic          m_fault [ND];

    generate
        for (genvar d = 0; d < ND; d++) begin : g_dut
            sram_arbiter #(.RR(d == 0 ? 1 : 0)) u_dut (
                .clk      (clk),
                .rstn     (rstn[d]),
                .s0_addr  (s_addr[d][0]),
                .s0_w_rb  (s_w_rb[d][0]),
                .s0_acc   (s_acc[d][0]),
                .s0_wdata (s_wdata[d][0]),
                .s0_req   (s_req[d][0]),
                .s0_rdata (s_rdata[d][0]),
                .s0_resp  (s_resp[d][0]),
                .s0_fault (s_fault[d][0]),
                .s1_addr  (s_addr[d][1]),
                .s1_w_rb  (s_w_rb[d][1]),
                .s1_acc   (s_acc[d][1]),
                .s1_wdata (s_wdata[d][1]),
                .s1_req   (s_req[d][1]),
                .s1_rdata (s_rdata[d][1]),
                .s1_resp  (s_resp[d][1]),
                .s1_fault (s_fault[d][1]),
                .m_addr   (m_addr[d]),
                .m_w_rb   (m_w_rb[d]),
                .m_acc    (m_acc[d]),
                .m_wdata  (m_wdata[d]),
                .m_req    (m_req[d]),
                .m_rdata  (m_rdata[d]),
                .m_resp   (m_resp[d]),
                .m_fault  (m_fault[d])
            );
        end
    endgenerate

    // Reference model: pending requests per port, the access in flight, and
    // the cycle numbers at which the next grant and its response occur.
    bit            pv   [ND][2];
    logic [VA-1:0] pa   [ND][2];
    logic          pw   [ND][2];
    logic [AW-1:0] pacc [ND][2];
    logic [BW-1:0] pd   [ND][2];
    int            last [ND];
    int            own  [ND];
    int            gnt_at [ND];
    int            rsp_at [ND];
    bit            outst  [ND];
    bit            dut_out[ND];
    int            dly_fix[ND];
    bit            rd_fix_en;
    logic [BW-1:0] rd_fix;
    int            cyc;
    int            n_vec;
    int            n_err;
    logic [VA-1:0] gq0[$];
    logic [VA-1:0] gq1[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit mis(input logic [VA-1:0] a, input logic [AW-1:0] acc);
        int sz;
        sz = (acc == BUS_ACC_1B) ? 1 : (acc == BUS_ACC_2B) ? 2 : 4;
        return (int'(a) % sz) != 0;
    endfunction

    function automatic bit model_busy(input int d);
        return pv[d][0] || pv[d][1] || outst[d] || gnt_at[d] >= 0;
    endfunction

    task automatic model_reset(input int d);
        pv[d][0] = 1'b0;
        pv[d][1] = 1'b0;
        last[d]   = 1;
        outst[d]  = 1'b0;
        gnt_at[d] = -1;
        rsp_at[d] = -1;
    endtask

    task automatic clr_req();
        for (int d = 0; d < ND; d++)
            for (int p = 0; p < 2; p++) s_req[d][p] = 1'b0;
    endtask

    task automatic put(input int d, input int p, input logic [VA-1:0] a, input logic w,
                       input logic [AW-1:0] acc, input logic [BW-1:0] wd);
        s_req[d][p]   = 1'b1;
        s_addr[d][p]  = a;
        s_w_rb[d][p]  = w;
        s_acc[d][p]   = acc;
        s_wdata[d][p] = wd;
    endtask

    // One clock cycle: respond downstream, check outputs mid-cycle, advance model.
    task automatic tick();
        bit fexp[2];
        bit rexp[2];
        bit mreq_e, drv, dec, rr;
        for (int d = 0; d < ND; d++) begin
            m_resp[d]  = rstn[d] && outst[d] && (cyc == rsp_at[d]);
            m_rdata[d] = rd_fix_en ? rd_fix : BW'($urandom);
        end
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            rr = (d == 0);
            for (int p = 0; p < 2; p++) begin
                rexp[p] = m_resp[d] && (own[d] == p);
                fexp[p] = s_req[d][p] && (mis(s_addr[d][p], s_acc[d][p]) || (pv[d][p] && !rexp[p]));
                chk($sformatf("d%0d_fault%0d", d, p), 32'(s_fault[d][p]), 32'(fexp[p]));
                chk($sformatf("d%0d_resp%0d", d, p), 32'(s_resp[d][p]), 32'(rexp[p]));
                chk($sformatf("d%0d_rdata%0d", d, p), s_rdata[d][p], rexp[p] ? m_rdata[d] : 32'd0);
                chk($sformatf("d%0d_resp_empty%0d", d, p), 32'(s_resp[d][p] && !pv[d][p]), 32'd0);
            end
            mreq_e = rstn[d] && (gnt_at[d] == cyc);
            drv    = rstn[d] && (outst[d] || mreq_e);
            chk($sformatf("d%0d_mreq", d), 32'(m_req[d]), 32'(mreq_e));
            chk($sformatf("d%0d_maddr", d), 32'(m_addr[d]), drv ? 32'(pa[d][own[d]]) : 32'd0);
            chk($sformatf("d%0d_mwrb", d), 32'(m_w_rb[d]), drv ? 32'(pw[d][own[d]]) : 32'd0);
            chk($sformatf("d%0d_macc", d), 32'(m_acc[d]), drv ? 32'(pacc[d][own[d]]) : 32'd0);
            chk($sformatf("d%0d_mwdata", d), m_wdata[d], drv ? pd[d][own[d]] : 32'd0);
            chk($sformatf("d%0d_mreq_dup", d), 32'(m_req[d] && dut_out[d]), 32'd0);
            if (!rstn[d] || m_resp[d]) dut_out[d] = 1'b0;
            if (m_req[d]) begin
                dut_out[d] = 1'b1;
                if (d == 0) gq0.push_back(m_addr[d]);
                else        gq1.push_back(m_addr[d]);
            end

            if (!rstn[d]) begin
                model_reset(d);
            end else begin
                dec = !outst[d] && gnt_at[d] < 0 && (pv[d][0] || pv[d][1]);
                if (m_resp[d]) begin
                    pv[d][own[d]] = 1'b0;
                    last[d]       = own[d];
                    outst[d]      = 1'b0;
                end
                if (gnt_at[d] == cyc) begin
                    outst[d]  = 1'b1;
                    gnt_at[d] = -1;
                    rsp_at[d] = cyc + ((dly_fix[d] != 0) ? dly_fix[d] : int'($urandom_range(1, 3)));
                end else if (dec) begin
                    if (pv[d][0] && pv[d][1]) own[d] = rr ? 1 - last[d] : 0;
                    else                      own[d] = pv[d][0] ? 0 : 1;
                    gnt_at[d] = cyc + 1;
                end
                for (int p = 0; p < 2; p++) begin
                    if (s_req[d][p] && !fexp[p]) begin
                        pv[d][p]   = 1'b1;
                        pa[d][p]   = s_addr[d][p];
                        pw[d][p]   = s_w_rb[d][p];
                        pacc[d][p] = s_acc[d][p];
                        pd[d][p]   = s_wdata[d][p];
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        clr_req();
    endtask

    task automatic wait_idle(input int d, input int budget);
        int k;
        k = 0;
        while (model_busy(d) && k < budget) begin
            tick();
            k++;
        end
        chk($sformatf("d%0d_idle_timeout", d), 32'(model_busy(d)), 32'd0);
    endtask

    initial begin
        int rounds;
        logic [VA-1:0] exp0[4];
        logic [VA-1:0] exp1[5];
        n_vec = 0; n_err = 0; cyc = 0;
        rd_fix_en = 1'b0; rd_fix = '0;
        for (int d = 0; d < ND; d++) begin
            rstn[d] = 1'b0; m_fault[d] = 1'b0; m_resp[d] = 1'b0; m_rdata[d] = '0;
            own[d] = 0; dly_fix[d] = 0; dut_out[d] = 1'b0;
            model_reset(d);
            for (int p = 0; p < 2; p++) begin
                s_addr[d][p] = '0; s_w_rb[d][p] = 1'b0; s_acc[d][p] = '0; s_wdata[d][p] = '0;
                pa[d][p] = '0; pw[d][p] = 1'b0; pacc[d][p] = '0; pd[d][p] = '0;
            end
        end
        clr_req();
        @(posedge clk);
        #1;
        repeat (2) tick();
        rstn[0] = 1'b1; rstn[1] = 1'b1;

        // Single 4B read from port 0 with a fixed return word.
        rd_fix_en = 1'b1; rd_fix = 32'hDEADBEEF;
        put(0, 0, 16'h0100, 1'b0, BUS_ACC_4B, 32'h0);
        tick();
        wait_idle(0, 20);
        rd_fix_en = 1'b0;

        // RR=1: simultaneous requests after reset alternate 0,1,0,1.
        rstn[0] = 1'b0; tick(); rstn[0] = 1'b1;
        gq0.delete();
        for (int r = 0; r < 2; r++) begin
            put(0, 0, 16'h0010, 1'b0, BUS_ACC_4B, 32'h0);
            put(0, 1, 16'h0020, 1'b1, BUS_ACC_4B, 32'h1234_5678);
            tick();
            wait_idle(0, 30);
        end
        exp0 = '{16'h0010, 16'h0020, 16'h0010, 16'h0020};
        chk("rr_order_len", 32'(gq0.size()), 32'd4);
        for (int i = 0; i < 4 && i < gq0.size(); i++)
            chk($sformatf("rr_order%0d", i), 32'(gq0[i]), 32'(exp0[i]));

        // RR=0: port 0 re-requests in each of its completion cycles and starves port 1.
        gq1.delete();
        rounds = 0;
        put(1, 0, 16'h0030, 1'b0, BUS_ACC_2B, 32'h0);
        put(1, 1, 16'h0040, 1'b1, BUS_ACC_1B, 32'hA5);
        tick();
        for (int k = 0; k < 60; k++) begin
            if (!model_busy(1)) break;
            if (rounds < 3 && outst[1] && cyc == rsp_at[1] && own[1] == 0) begin
                put(1, 0, 16'h0030, 1'b0, BUS_ACC_2B, 32'h0);
                rounds++;
            end
            tick();
        end
        exp1 = '{16'h0030, 16'h0030, 16'h0030, 16'h0030, 16'h0040};
        chk("fp_order_len", 32'(gq1.size()), 32'd5);
        for (int i = 0; i < 5 && i < gq1.size(); i++)
            chk($sformatf("fp_order%0d", i), 32'(gq1[i]), 32'(exp1[i]));

        // Misaligned request and a second request into a busy slot.
        put(0, 1, 16'h0101, 1'b0, BUS_ACC_2B, 32'h0);
        tick();
        put(0, 0, 16'h0200, 1'b1, BUS_ACC_4B, 32'hCAFE_0001);
        tick();
        put(0, 0, 16'h0204, 1'b1, BUS_ACC_4B, 32'hCAFE_0002);
        tick();
        wait_idle(0, 20);

        // Reset while a port-1 write is waiting for its response.
        dly_fix[0] = 6;
        put(0, 1, 16'h0300, 1'b1, BUS_ACC_4B, 32'h0BAD_F00D);
        tick();
        for (int k = 0; k < 10 && !outst[0]; k++) tick();
        chk("wait_reached", 32'(outst[0]), 32'd1);
        repeat (2) tick();
        rstn[0] = 1'b0; tick(); rstn[0] = 1'b1;
        dly_fix[0] = 0;
        repeat (8) tick();
        put(0, 0, 16'h0400, 1'b0, BUS_ACC_1B, 32'h0);
        tick();
        wait_idle(0, 20);

        // Random traffic on both instances, with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            for (int d = 0; d < ND; d++) begin
                rstn[d] = ($urandom_range(0, 79) != 0);
                if (rstn[d]) begin
                    for (int p = 0; p < 2; p++)
                        if ($urandom_range(0, 99) < 35)
                            put(d, p, VA'($urandom), 1'($urandom), AW'($urandom_range(0, 2)), BW'($urandom));
                end
            end
            tick();
        end
        rstn[0] = 1'b1; rstn[1] = 1'b1;
        wait_idle(0, 40);
        wait_idle(1, 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter RR, default 1, meaning 1 = round-robin, 0 = fixed priority with port 0 highest.
REQ-002 clk  input  1  system clock, <100MHz, shared with sram_controller.
REQ-003 rstn  input  1  reset; synchronous, active-low.
REQ-004 s{0,1}_addr  input  SRAM_VA_WIDTH  requester byte address.
REQ-005 s{0,1}_w_rb  input  1  1 = write, 0 = read.
REQ-006 s{0,1}_acc  input  BUS_ACC_WIDTH  access size (1B/2B/4B encoding).
REQ-007 s{0,1}_wdata  input  BUS_WIDTH  write data.
REQ-008 s{0,1}_req  input  1  single-cycle request pulse.
REQ-009 s{0,1}_rdata  output  BUS_WIDTH  read data, valid with s{0,1}_resp.
REQ-010 s{0,1}_resp  output  1  single-cycle completion pulse.
REQ-011 s{0,1}_fault  output  1  combinational reject, same cycle as s{0,1}_req.
REQ-012 m_addr, m_w_rb, m_acc, m_wdata, m_req  output  same widths  downstream request to sram_controller.
REQ-013 m_rdata, m_resp, m_fault  input  same widths  downstream response; m_fault unused, never expected.

Function
REQ-014 Each port SHALL own one pending slot (addr, w_rb, acc, wdata, valid).
REQ-015 sN_fault = sN_req & (misaligned | slot busy); misaligned = (addr[0]=1 & acc!=1B) | (addr[1:0]=2 & acc=4B).
REQ-016 A non-faulting sN_req SHALL load slot N at the next clk edge; a faulting req SHALL leave all state unchanged.
REQ-017 A slot is busy from the load edge until the edge ending the cycle its sN_resp is high; a req in the resp cycle is accepted.
REQ-018 FSM states IDLE, ISSUE, WAIT; reset state IDLE.
REQ-019 IDLE: if any slot valid, select winner, set owner, go ISSUE; else stay.
REQ-020 Winner: single valid slot wins; both valid -> RR=1: port != last_owner, RR=0: port 0.
REQ-021 ISSUE: m_req=1 for exactly this one cycle, m_* driven from owner slot; go WAIT.
REQ-022 m_addr/m_w_rb/m_acc/m_wdata SHALL hold owner slot contents in ISSUE and WAIT; zero in IDLE.
REQ-023 WAIT: on m_resp, s{owner}_resp=1 combinationally, s{owner}_rdata=m_rdata, clear owner slot valid, last_owner<=owner, go IDLE.
REQ-024 Non-owner sN_resp SHALL be 0; sN_rdata SHALL be 0 when sN_resp=0.
REQ-025 Minimum latency sN_req to m_req: 2 cycles (load, IDLE select, ISSUE); back-to-back grants separated by one IDLE cycle.
REQ-026 m_req SHALL never assert while a previous downstream access is outstanding.

Reset
REQ-027 rstn low at any clk edge: state IDLE, slot valids 0, last_owner=1, m_req=0, sN_resp=0, including mid-WAIT.
REQ-028 Outputs during/after reset: all sN_resp, m_req, sN_rdata, m_* = 0; sN_fault combinational only.

Structure
REQ-029 Misalignment check and BUS_ACC_* encodings SHALL come from the shared bus header, not be redefined locally.
REQ-030 FSM state encodings SHALL be local constants; no new package types.
REQ-031 Slot SHALL be a sub-module sram_arb_slot (load, clear, valid, payload), instantiated twice, built on the common dff cell.

Verification
REQ-032 s0 read 4B addr 0x100 alone -> m_req 2 cycles later, m_addr=0x100; m_resp with m_rdata=0xDEADBEEF -> s0_resp=1, s0_rdata=0xDEADBEEF, s1_resp=0.
REQ-033 s0 and s1 req same cycle, RR=1, after reset -> port 0 served first, then port 1; repeated twice -> order alternates 0,1,0,1.
REQ-034 RR=0, s0 re-requests every resp cycle while s1 pending -> s0 always granted; s1 served only when s0 slot empty.
REQ-035 s1 req addr 0x101 acc 2B -> s1_fault=1 same cycle, no slot load, m_req stays 0; s0 second req while slot busy -> s0_fault=1.
REQ-036 rstn low during WAIT of s1 write -> next cycle state IDLE, slots empty, no s1_resp; fresh s0 req serviced normally.
REQ-037 Bench SHALL assert m_req never high twice without intervening m_resp and sN_resp never high with slot empty.
